// File: rtl/stage_if_pkg.sv
// stage_if_pkg
// Shared constants and types for the instruction-fetch (IF) stage:
//   RESET_ENABLE    - level of 'reset' that puts the stage into its reset state
//   WRITE_ENABLE    - level of 'pc_write_enable' that requests a redirect
//   PC_RESET_VECTOR - fetch address used after reset
//   if_state_e      - IF controller states (IDLE, REQ, FULL)
package stage_if_pkg;

   localparam logic        RESET_ENABLE    = 1'b1;
   localparam logic        WRITE_ENABLE    = 1'b1;
   localparam logic [31:0] PC_RESET_VECTOR = 32'h0000_0000;

   // IDLE: first cycle after reset release
   // REQ : a fetch is outstanding on the instruction-memory bus
   // FULL: a fetched word is parked in the hold buffer while ID is stalled
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      FULL = 2'd2
   } if_state_e;

endpackage

// File: rtl/stage_if_if.sv
// stage_if_if
// Instruction-memory read bus between the IF stage and instruction memory.
//   imem_request  - read request (driven by IF)
//   imem_address  - word address of the request (driven by IF)
//   imem_ready    - read complete, imem_data valid this cycle (driven by memory)
//   imem_data     - returned instruction word (driven by memory)
// Modports: master = IF stage side, slave = memory side.
interface stage_if_if;

   logic        imem_request;
   logic [31:0] imem_address;
   logic        imem_ready;
   logic [31:0] imem_data;

   modport master (
      output imem_request,
      output imem_address,
      input  imem_ready,
      input  imem_data
   );

   modport slave (
      input  imem_request,
      input  imem_address,
      output imem_ready,
      output imem_data
   );

endinterface

// File: rtl/if_hold_buffer.sv
// if_hold_buffer
// One-entry buffer that parks a fetched word and its PC while ID is stalled.
//   clock, reset       - rising-edge clock, asynchronous active-high reset
//   load               - capture load_data/load_pc and mark the entry valid
//   load_data, load_pc - word and PC to capture
//   drain              - entry has been handed to ID; mark it empty
//   buf_data, buf_pc   - buffered word and PC
//   buf_valid          - entry holds a word not yet handed to ID
module if_hold_buffer
   import stage_if_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        load,
   input  logic [31:0] load_data,
   input  logic [31:0] load_pc,
   input  logic        drain,
   output logic [31:0] buf_data,
   output logic [31:0] buf_pc,
   output logic        buf_valid
);

   logic [31:0] data_q, data_d;
   logic [31:0] pc_q, pc_d;
   logic        valid_q, valid_d;

   // A load always wins over a drain; draining only clears the valid flag and
   // leaves the stale data in place since nobody looks at it once invalid.
   always_comb begin
      data_d  = data_q;
      pc_d    = pc_q;
      valid_d = valid_q;
      if (load) begin
         data_d  = load_data;
         pc_d    = load_pc;
         valid_d = 1'b1;
      end else if (drain) begin
         valid_d = 1'b0;
      end
   end

   // Entry register, cleared asynchronously so a reset mid-stall drops the word.
   always_ff @(posedge clock or posedge reset) begin
      if (reset == RESET_ENABLE) begin
         data_q  <= '0;
         pc_q    <= '0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         pc_q    <= pc_d;
         valid_q <= valid_d;
      end
   end

   assign buf_data  = data_q;
   assign buf_pc    = pc_q;
   assign buf_valid = valid_q;

endmodule

// File: rtl/stage_if.sv
// stage_if
// Instruction-fetch stage: issues word reads to instruction memory, presents
// fetched words to ID, parks one word while ID stalls and follows redirects
// from ID with a single delay slot.
//   clock, reset      - rising-edge clock, asynchronous active-high reset
//   stall             - 1 = ID does not consume this cycle
//   pc_write_enable   - redirect request from ID
//   pc_write_data     - redirect target from ID
//   imem              - instruction-memory bus (stage_if_if.master)
//   instruction_o     - instruction presented to ID
//   pc_read_data      - PC of instruction_o
//   instruction_valid - instruction_o holds a real fetched instruction
//   fetch_fault       - one-cycle pulse on a misaligned redirect
// Build option: define IF_ALIGN_CHECK_EN to force redirect targets onto a word
// boundary and flag misaligned ones on fetch_fault; otherwise fetch_fault is 0
// and targets are used as given.
module stage_if
   import stage_if_pkg::*;
(
   input  logic          clock,
   input  logic          reset,
   input  logic          stall,
   input  logic          pc_write_enable,
   input  logic [31:0]   pc_write_data,
   stage_if_if.master    imem,
   output logic [31:0]   instruction_o,
   output logic [31:0]   pc_read_data,
   output logic          instruction_valid,
   output logic          fetch_fault
);

   if_state_e   state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic        redirect_pending_q, redirect_pending_d;
   logic [31:0] redirect_target_q, redirect_target_d;
   logic [31:0] instruction_q, instruction_d;
   logic [31:0] pc_out_q, pc_out_d;
   logic        valid_q, valid_d;

   logic        word_done;
   logic        redirect_accept;
   logic [31:0] new_target;
   logic [31:0] seq_pc;
   logic        buf_load, buf_drain;
   logic [31:0] buf_data, buf_pc;
   logic        buf_valid;

   if_hold_buffer u_hold (
      .clock     (clock),
      .reset     (reset),
      .load      (buf_load),
      .load_data (imem.imem_data),
      .load_pc   (fetch_pc_q),
      .drain     (buf_drain),
      .buf_data  (buf_data),
      .buf_pc    (buf_pc),
      .buf_valid (buf_valid)
   );

   // A redirect is only meaningful while ID actually holds a valid instruction
   // that it is consuming this cycle (the branch itself).
   assign word_done       = (state_q == REQ) && imem.imem_ready;
   assign redirect_accept = (pc_write_enable == WRITE_ENABLE) && !stall && valid_q;

`ifdef IF_ALIGN_CHECK_EN
   logic fault_q, fault_d;

   assign new_target = {pc_write_data[31:2], 2'b00};

   // Misalignment flag lasts exactly one cycle after the accepting edge.
   always_comb begin
      fault_d = redirect_accept && (pc_write_data[1:0] != 2'b00);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset == RESET_ENABLE) fault_q <= 1'b0;
      else                       fault_q <= fault_d;
   end

   assign fetch_fault = fault_q;
`else
   assign new_target  = pc_write_data;
   assign fetch_fault = 1'b0;
`endif

   // Next-state, fetch-PC and output-register logic. The word in flight (or
   // parked in the buffer) when a redirect is accepted is the delay slot: it
   // completes normally, and only the fetch after it uses the target. When
   // that delay slot is already done this same edge, the target goes straight
   // into fetch_pc instead of being remembered as pending.
   always_comb begin
      state_d            = state_q;
      fetch_pc_d         = fetch_pc_q;
      redirect_pending_d = redirect_pending_q;
      redirect_target_d  = redirect_target_q;
      instruction_d      = instruction_q;
      pc_out_d           = pc_out_q;
      valid_d            = valid_q;
      buf_load           = 1'b0;
      buf_drain          = 1'b0;
      seq_pc             = redirect_pending_q ? redirect_target_q : (fetch_pc_q + 32'd4);

      case (state_q)
         IDLE: state_d = REQ;
         REQ: begin
            if (word_done) begin
               fetch_pc_d         = seq_pc;
               redirect_pending_d = 1'b0;
               if (stall) begin
                  buf_load = 1'b1;
                  state_d  = FULL;
               end
            end
         end
         FULL: begin
            if (!stall) begin
               buf_drain = 1'b1;
               state_d   = REQ;
            end
         end
         default: state_d = IDLE;
      endcase

      if (!stall) begin
         if (word_done) begin
            instruction_d = imem.imem_data;
            pc_out_d      = fetch_pc_q;
            valid_d       = 1'b1;
         end else if (state_q == FULL && buf_valid) begin
            instruction_d = buf_data;
            pc_out_d      = buf_pc;
            valid_d       = 1'b1;
         end else begin
            instruction_d = '0;
            pc_out_d      = '0;
            valid_d       = 1'b0;
         end
      end

      if (redirect_accept) begin
         if (word_done || state_q == FULL) begin
            fetch_pc_d         = new_target;
            redirect_pending_d = 1'b0;
         end else begin
            redirect_target_d  = new_target;
            redirect_pending_d = 1'b1;
         end
      end
   end

   // State register; reset abandons any outstanding request immediately.
   always_ff @(posedge clock or posedge reset) begin
      if (reset == RESET_ENABLE) begin
         state_q            <= IDLE;
         fetch_pc_q         <= PC_RESET_VECTOR;
         redirect_pending_q <= 1'b0;
         redirect_target_q  <= '0;
         instruction_q      <= '0;
         pc_out_q           <= '0;
         valid_q            <= 1'b0;
      end else begin
         state_q            <= state_d;
         fetch_pc_q         <= fetch_pc_d;
         redirect_pending_q <= redirect_pending_d;
         redirect_target_q  <= redirect_target_d;
         instruction_q      <= instruction_d;
         pc_out_q           <= pc_out_d;
         valid_q            <= valid_d;
      end
   end

   assign imem.imem_request = (state_q == REQ);
   assign imem.imem_address = fetch_pc_q;
   assign instruction_o     = instruction_q;
   assign pc_read_data      = pc_out_q;
   assign instruction_valid = valid_q;

endmodule
